// File: rtl/l2_refill_pkg.sv
// ---------------------------------------------------------------------------
// l2_refill_pkg
// Shared types and helpers for the L2 line refill controller.
//   refill_state_t : controller FSM states
//   OFF_W          : word-index width for the default 4-word line
//   BYTE_OFF_W     : byte-offset width for the default 32-bit word
//   line_base()    : clears the low offset bits of an address
// ---------------------------------------------------------------------------
package l2_refill_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB,
    RD,
    DRAIN,
    DONE
  } refill_state_t;

  localparam int WORDS_PER_LINE_DEF = 4;
  localparam int DATA_W_DEF         = 32;
  localparam int OFF_W              = $clog2(WORDS_PER_LINE_DEF);
  localparam int BYTE_OFF_W         = $clog2(DATA_W_DEF / 8);

  // Widest address the helper handles; callers size-cast in and out.
  localparam int ADDR_MAX_W = 64;

  // Line base: zero the byte-offset and word-index bits so that OR-ing a
  // word offset back in can never carry into the tag bits.
  function automatic logic [ADDR_MAX_W-1:0] line_base(
    input logic [ADDR_MAX_W-1:0] addr,
    input int unsigned           low_w
  );
    logic [ADDR_MAX_W-1:0] mask;
    mask = '1;
    mask = mask << low_w;
    return addr & mask;
  endfunction

endpackage

// File: rtl/l2_rd_return_pipe.sv
// ---------------------------------------------------------------------------
// l2_rd_return_pipe
// DEPTH-deep shift register of {valid, tag} that tracks read issues until
// their data comes back from the L2 arbiter DEPTH cycles later.
//   clk, rst_n : clock, async active-low reset (pipe empties)
//   push_i     : a read was granted this cycle
//   tag_i      : word index of that read
//   valid_o    : tag_o describes the data on the bus this cycle
//   tag_o      : word index of the returning data
//   empty_o    : no read in flight anywhere in the pipe
// ---------------------------------------------------------------------------
module l2_rd_return_pipe #(
  parameter int DEPTH = 1,
  parameter int TAG_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             empty_o
);

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= push_i;
      tag_q[0]   <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign tag_o   = tag_q[DEPTH-1];
  assign empty_o = ~|valid_q;

endmodule

// File: rtl/l2_line_refill_ctrl.sv
// ---------------------------------------------------------------------------
// l2_line_refill_ctrl
// Sequences one whole-line miss on a cache's port of the L2 bus arbiter:
// optional dirty-line writeback (WORDS_PER_LINE word writes), then the line
// refill (WORDS_PER_LINE word reads) whose returned words are streamed into
// the cache data array.
//
// Ports
//   clk, rst_n       : clock, async active-low reset (abandons a line)
//   req_valid/ready  : miss request handshake
//   req_wb           : victim is dirty, write it back first
//   req_wb_addr      : victim line address (offset bits ignored)
//   req_fill_addr    : miss line address (offset bits ignored)
//   wb_rd_idx        : word index into the victim line
//   wb_rd_data       : victim word at wb_rd_idx (combinational)
//   fill_valid/idx/data : returned refill word for the data array
//   done             : one-cycle pulse when the line is complete
//   busy             : controller not idle
//   l2_mem_*         : request/response signals of the arbiter port
//   rd_grant/wr_grant: arbiter grants for this port
//   state_dbg        : current FSM state
//
// Handshakes: a request is taken on a cycle where req_valid & req_ready,
// and req_ready is high only in IDLE (never in DONE). Toward the arbiter,
// l2_mem_en with a fixed addr/wr_data is held until the matching grant
// arrives; a word is consumed on the cycle en & grant are both high.
// ---------------------------------------------------------------------------
module l2_line_refill_ctrl
  import l2_refill_pkg::*;
#(
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int RD_LAT         = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_wb,
  input  logic [ADDR_W-1:0]                 req_wb_addr,
  input  logic [ADDR_W-1:0]                 req_fill_addr,
  output logic [$clog2(WORDS_PER_LINE)-1:0] wb_rd_idx,
  input  logic [DATA_W-1:0]                 wb_rd_data,
  output logic                              fill_valid,
  output logic [$clog2(WORDS_PER_LINE)-1:0] fill_idx,
  output logic [DATA_W-1:0]                 fill_data,
  output logic                              done,
  output logic                              busy,
  output logic                              l2_mem_en,
  output logic                              l2_mem_wr_en,
  output logic [ADDR_W-1:0]                 l2_mem_addr,
  output logic [DATA_W-1:0]                 l2_mem_wr_data,
  input  logic [DATA_W-1:0]                 l2_mem_rd_data,
  input  logic                              rd_grant,
  input  logic                              wr_grant,
  output refill_state_t                     state_dbg
);

  localparam int          IDX_W  = $clog2(WORDS_PER_LINE);
  localparam int          BOFF_W = $clog2(DATA_W / 8);
  localparam int unsigned LOW_W  = BOFF_W + IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);

  refill_state_t     state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] wb_base_q, wb_base_d;
  logic [ADDR_W-1:0] fill_base_q, fill_base_d;
  logic [ADDR_W-1:0] word_off;

  logic              rd_issue;
  logic              pipe_valid;
  logic              pipe_empty;
  logic [IDX_W-1:0]  pipe_idx;

  // Bases have their offset bits cleared, so OR-ing the word offset is safe.
  assign word_off = ADDR_W'(idx_q) << BOFF_W;

  // Only a read grant seen while the read request is actually up counts.
  assign rd_issue = (state_q == RD) && rd_grant;

  l2_rd_return_pipe #(
    .DEPTH (RD_LAT),
    .TAG_W (IDX_W)
  ) u_ret_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rd_issue),
    .tag_i   (idx_q),
    .valid_o (pipe_valid),
    .tag_o   (pipe_idx),
    .empty_o (pipe_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wb_base_q   <= '0;
      fill_base_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wb_base_q   <= wb_base_d;
      fill_base_q <= fill_base_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    wb_base_d      = wb_base_q;
    fill_base_d    = fill_base_q;
    req_ready      = 1'b0;
    busy           = 1'b1;
    done           = 1'b0;
    l2_mem_en      = 1'b0;
    l2_mem_wr_en   = 1'b0;
    l2_mem_addr    = '0;
    l2_mem_wr_data = '0;
    wb_rd_idx      = '0;

    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          wb_base_d   = ADDR_W'(line_base(ADDR_MAX_W'(req_wb_addr), LOW_W));
          fill_base_d = ADDR_W'(line_base(ADDR_MAX_W'(req_fill_addr), LOW_W));
          idx_d       = '0;
          state_d     = req_wb ? WB : RD;
        end
      end

      WB: begin
        l2_mem_en      = 1'b1;
        l2_mem_wr_en   = 1'b1;
        l2_mem_addr    = wb_base_q | word_off;
        l2_mem_wr_data = wb_rd_data;
        wb_rd_idx      = idx_q;
        if (wr_grant) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = RD;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      RD: begin
        l2_mem_en   = 1'b1;
        l2_mem_addr = fill_base_q | word_off;
        if (rd_grant) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      DRAIN: begin
        // Reads return in issue order, so the last index leaving the pipe
        // means the whole line has been delivered.
        if (pipe_empty || (pipe_valid && (pipe_idx == LAST_IDX))) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fill_valid = pipe_valid;
  assign fill_idx   = pipe_valid ? pipe_idx : '0;
  assign fill_data  = pipe_valid ? l2_mem_rd_data : '0;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_l2_line_refill_ctrl.sv
// ---------------------------------------------------------------------------
// tb_l2_line_refill_ctrl
// Directed bench for l2_line_refill_ctrl (4 words/line, 32-bit, RD_LAT=1).
// Expected arbiter transactions, fill words and done timing are pushed into
// queues when stimulus is issued; a monitor on the falling edge pops and
// compares whenever the DUT presents them.
// ---------------------------------------------------------------------------
module tb_l2_line_refill_ctrl;
  import l2_refill_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int WPL = 4;
  localparam int IW  = 2;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wb;
  logic [AW-1:0] req_wb_addr;
  logic [AW-1:0] req_fill_addr;
  logic [IW-1:0] wb_rd_idx;
  logic [DW-1:0] wb_rd_data;
  logic          fill_valid;
  logic [IW-1:0] fill_idx;
  logic [DW-1:0] fill_data;
  logic          done;
  logic          busy;
  logic          l2_mem_en;
  logic          l2_mem_wr_en;
  logic [AW-1:0] l2_mem_addr;
  logic [DW-1:0] l2_mem_wr_data;
  logic [DW-1:0] l2_mem_rd_data;
  logic          rd_grant;
  logic          wr_grant;
  refill_state_t state_dbg;

  // Expected queues: {wr, addr, wr_data}, {idx, data}, done offset.
  logic [64:0] exp_l2_q[$];
  logic [33:0] exp_fill_q[$];
  logic [31:0] exp_done_q[$];

  int n_vec;
  int n_fail;
  int cyc;
  int accept_cyc;

  // ---------------- clock / reset / environment ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Victim line contents: word i reads as 0xD000_000i.
  always_comb wb_rd_data = 32'hD000_0000 | 32'(wb_rd_idx);

  // L2 responder with one cycle of read latency.
  initial l2_mem_rd_data = '0;
  always @(posedge clk) begin
    if (l2_mem_en && !l2_mem_wr_en && rd_grant) begin
      l2_mem_rd_data <= l2_mem_addr ^ 32'hA5A5_0000;
    end
  end

  l2_line_refill_ctrl #(
    .WORDS_PER_LINE (WPL),
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .RD_LAT         (1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wb         (req_wb),
    .req_wb_addr    (req_wb_addr),
    .req_fill_addr  (req_fill_addr),
    .wb_rd_idx      (wb_rd_idx),
    .wb_rd_data     (wb_rd_data),
    .fill_valid     (fill_valid),
    .fill_idx       (fill_idx),
    .fill_data      (fill_data),
    .done           (done),
    .busy           (busy),
    .l2_mem_en      (l2_mem_en),
    .l2_mem_wr_en   (l2_mem_wr_en),
    .l2_mem_addr    (l2_mem_addr),
    .l2_mem_wr_data (l2_mem_wr_data),
    .l2_mem_rd_data (l2_mem_rd_data),
    .rd_grant       (rd_grant),
    .wr_grant       (wr_grant),
    .state_dbg      (state_dbg)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got %0h with nothing expected (t=%0t)", name, act, $time);
  endtask

  task automatic chk_idle_outputs(input string tag);
    check({tag, "_req_ready"},  64'(req_ready), 64'd1);
    check({tag, "_busy"},       64'(busy), 64'd0);
    check({tag, "_done"},       64'(done), 64'd0);
    check({tag, "_fill_valid"}, 64'(fill_valid), 64'd0);
    check({tag, "_fill_idx"},   64'(fill_idx), 64'd0);
    check({tag, "_fill_data"},  64'(fill_data), 64'd0);
    check({tag, "_en"},         64'(l2_mem_en), 64'd0);
    check({tag, "_wr_en"},      64'(l2_mem_wr_en), 64'd0);
    check({tag, "_addr"},       64'(l2_mem_addr), 64'd0);
    check({tag, "_wr_data"},    64'(l2_mem_wr_data), 64'd0);
    check({tag, "_wb_rd_idx"},  64'(wb_rd_idx), 64'd0);
    check({tag, "_state"},      64'(state_dbg), 64'(IDLE));
  endtask

  task automatic chk_queues_empty(input string tag);
    check({tag, "_l2_left"},   64'(exp_l2_q.size()), 64'd0);
    check({tag, "_fill_left"}, 64'(exp_fill_q.size()), 64'd0);
    check({tag, "_done_left"}, 64'(exp_done_q.size()), 64'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (l2_mem_en) begin
        if (exp_l2_q.size() == 0) begin
          unexpected("l2_req", 64'(l2_mem_addr));
        end else begin
          logic [64:0] e;
          e = exp_l2_q[0];
          check("l2_wr_en", 64'(l2_mem_wr_en), 64'(e[64]));
          check("l2_addr", 64'(l2_mem_addr), 64'(e[63:32]));
          if (e[64]) check("l2_wr_data", 64'(l2_mem_wr_data), 64'(e[31:0]));
          if (e[64] ? wr_grant : rd_grant) void'(exp_l2_q.pop_front());
        end
      end
      if (fill_valid) begin
        if (exp_fill_q.size() == 0) begin
          unexpected("fill", 64'(fill_idx));
        end else begin
          logic [33:0] f;
          f = exp_fill_q.pop_front();
          check("fill_idx", 64'(fill_idx), 64'(f[33:32]));
          check("fill_data", 64'(fill_data), 64'(f[31:0]));
        end
      end
      if (done) begin
        if (exp_done_q.size() == 0) begin
          unexpected("done", 64'(cyc - accept_cyc));
        end else begin
          check("done_cycle", 64'(cyc - accept_cyc), 64'(exp_done_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Expected traffic for one line from hand-computed line bases.
  task automatic exp_line(input logic wb, input logic [31:0] wb_base,
                          input logic [31:0] fill_base, input int done_off);
    for (int i = 0; i < WPL; i++) begin
      if (wb) exp_l2_q.push_back({1'b1, wb_base + 32'(4 * i), 32'hD000_0000 | 32'(i)});
    end
    for (int i = 0; i < WPL; i++) begin
      exp_l2_q.push_back({1'b0, fill_base + 32'(4 * i), 32'h0});
      exp_fill_q.push_back({2'(i), (fill_base + 32'(4 * i)) ^ 32'hA5A5_0000});
    end
    exp_done_q.push_back(32'(done_off));
  endtask

  // Cycle k=0 is the accept cycle; grants for cycle k come from bit k.
  task automatic drive(input logic wb, input logic [31:0] wb_addr,
                       input logic [31:0] fill_addr, input logic [31:0] fill_addr2,
                       input logic [31:0] rd_pat, input logic [31:0] wr_pat,
                       input int valid_cycles, input int n_cyc, input string tag);
    for (int k = 0; k < n_cyc; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) accept_cyc = cyc;
      req_valid     = (k < valid_cycles);
      req_wb        = wb;
      req_wb_addr   = wb_addr;
      req_fill_addr = (k >= 2) ? fill_addr2 : fill_addr;
      rd_grant      = rd_pat[k];
      wr_grant      = wr_pat[k];
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_wb    = 1'b0;
    rd_grant  = 1'b0;
    wr_grant  = 1'b0;
    chk_queues_empty(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_vec         = 0;
    n_fail        = 0;
    accept_cyc    = 0;
    rst_n         = 1'b0;
    req_valid     = 1'b0;
    req_wb        = 1'b0;
    req_wb_addr   = '0;
    req_fill_addr = '0;
    rd_grant      = 1'b0;
    wr_grant      = 1'b0;

    repeat (2) @(posedge clk);
    #3;
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_idle_outputs("post_reset");

    // Refill only, grant every cycle: done 6 cycles after accept.
    exp_line(1'b0, 32'h0, 32'h0000_1230, 6);
    drive(1'b0, 32'h0, 32'h0000_1234, 32'h0000_1234, 32'hFFFF_FFFE, 32'h0, 1, 10, "refill");

    // Writeback then refill: writes 0x2000..0x200C, reads after 4th wr_grant.
    exp_line(1'b1, 32'h0000_2000, 32'h0000_3010, 10);
    drive(1'b1, 32'h0000_2008, 32'h0000_3010, 32'h0000_3010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 14, "wb_refill");

    // Read grant stalls 1,0,0,1,1,0,1 in cycles 1..7: fills 2,5,6,8, done 9.
    exp_line(1'b0, 32'h0, 32'h0000_4000, 9);
    drive(1'b0, 32'h0, 32'h0000_4000, 32'h0000_4000, 32'h0000_00B2, 32'h0, 1, 14, "stall");

    // Wrong grants: rd_grant in IDLE and WB, wr_grant throughout RD.
    // Writes granted in cycles 2,4,5,6; reads in 9..12; done 14.
    exp_line(1'b1, 32'h0000_A000, 32'h0000_B000, 14);
    drive(1'b1, 32'h0000_A00C, 32'h0000_B008, 32'h0000_B008, 32'hFFFF_FE7F, 32'hFFFF_FFF4, 1, 20, "wrong_grant");

    // Async reset during the 2nd fill word: only idx0/1 reads and fill idx0
    // are observed before reset; no done may follow.
    exp_l2_q.push_back({1'b0, 32'h0000_5000, 32'h0});
    exp_l2_q.push_back({1'b0, 32'h0000_5004, 32'h0});
    exp_fill_q.push_back({2'd0, 32'h0000_5000 ^ 32'hA5A5_0000});
    @(posedge clk);
    #1;
    accept_cyc    = cyc;
    req_valid     = 1'b1;
    req_wb        = 1'b0;
    req_fill_addr = 32'h0000_5000;
    rd_grant      = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("rst_pre_fill_valid", 64'(fill_valid), 64'd1);
    check("rst_pre_fill_idx", 64'(fill_idx), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    rd_grant = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_queues_empty("rst_abandon");
    repeat (3) @(posedge clk);

    // Next line after reset starts from word 0.
    exp_line(1'b0, 32'h0, 32'h0000_6000, 6);
    drive(1'b0, 32'h0, 32'h0000_6008, 32'h0000_6008, 32'hFFFF_FFFE, 32'h0, 1, 10, "after_rst");

    // req_valid held across DONE (cycle 6): second line accepted at cycle 7,
    // so its done lands at cycle 13.
    exp_line(1'b0, 32'h0, 32'h0000_7000, 6);
    exp_line(1'b0, 32'h0, 32'h0000_8000, 13);
    drive(1'b0, 32'h0, 32'h0000_7000, 32'h0000_8004, 32'hFFFF_FFFE, 32'h0, 8, 18, "b2b");

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
